// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one bit per clock.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - conversion request, sampled only while idle
//   bin   - binary operand, captured on the edge that accepts start
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse, bcd holds a new result
//   bcd   - packed BCD result, digit k at [4k+3:4k], digit 0 least significant
module bin2bcd_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned SW = 4 * D + W;

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4*D-1:0]  bcd_q, bcd_d;
  logic            done_q, done_d;

  logic [4*D-1:0]  adj;
  logic [SW-1:0]   sr_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // Add-3 correction on every digit, then shift {digits, binary} left by one so the
  // binary MSB enters digit 0.
  always_comb begin
    logic [3:0] dig;
    adj = '0;
    for (int unsigned k = 0; k < D; k++) begin
      dig = sr_q[W + 4*k +: 4];
      adj[4*k +: 4] = (dig >= 4'd5) ? 4'(dig + 4'd3) : dig;
    end
    sr_shift = {adj, sr_q[W-1:0]} << 1;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d    = {{(4*D){1'b0}}, bin};
          cnt_d   = CW'(W);
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = sr_shift[SW-1:W];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StConv);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: an 8-bit/3-digit and a 16-bit/5-digit instance,
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic [15:0] bin16 = '0;
  logic        busy8, done8, busy16, done16;
  logic [11:0] bcd8;
  logic [19:0] bcd16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(8), .D(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8)
  );

  bin2bcd_seq #(.W(16), .D(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16)
  );

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] ref_bcd(input int unsigned v, input int unsigned nd);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion on the selected instance. Optionally re-raises start mid-run with a
  // different operand, which must be ignored.
  task automatic run(input bit wide, input int unsigned v, input bit poke, input string tag);
    int k;
    int busy_cnt;
    bit d, b;
    logic [19:0] got;
    @(negedge clk);
    if (wide) begin start16 = 1'b1; bin16 = 16'(v); end
    else      begin start8  = 1'b1; bin8  = 8'(v);  end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    k = 0; busy_cnt = 0;
    forever begin
      d = wide ? done16 : done8;
      b = wide ? busy16 : busy8;
      if (d || k >= 40) break;
      if (b) busy_cnt++;
      if (poke && k == 3) begin
        if (wide) begin start16 = 1'b1; bin16 = 16'd7; end
        else      begin start8  = 1'b1; bin8  = 8'd7;  end
      end
      if (poke && k == 4) begin start8 = 1'b0; start16 = 1'b0; end
      @(negedge clk);
      k++;
    end
    got = wide ? bcd16 : {8'h0, bcd8};
    check({tag, " done"}, 32'(d), 32'd1);
    check({tag, " latency"}, 32'(k), wide ? 32'd16 : 32'd8);
    check({tag, " busy cycles"}, 32'(busy_cnt), wide ? 32'd16 : 32'd8);
    check({tag, " bcd"}, 32'(got), 32'(ref_bcd(v, wide ? 5 : 3)));
    @(negedge clk);
    check({tag, " done single"}, 32'(wide ? done16 : done8), 32'd0);
    check({tag, " idle after"}, 32'(wide ? busy16 : busy8), 32'd0);
  endtask

  initial begin
    int k;
    int gap;
    int pulses;

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset bcd", 32'(bcd8), 32'd0);
    rst = 1'b0;

    run(1'b0, 0, 1'b0, "zero");
    run(1'b0, 255, 1'b0, "max");
    run(1'b0, 99, 1'b0, "99");
    run(1'b0, 200, 1'b1, "ignore start");

    // bcd must hold while the next conversion runs.
    @(negedge clk); start8 = 1'b1; bin8 = 8'd17;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("bcd held in conv", 32'(bcd8), 32'h200);
    repeat (8) @(negedge clk);
    check("bcd 17", 32'(bcd8), 32'h017);

    // Start held high: one result every W+1 cycles.
    @(negedge clk); start8 = 1'b1; bin8 = 8'd128;
    k = 0;
    while (!done8 && k < 40) begin @(negedge clk); k++; end
    check("back2back first", 32'(done8), 32'd1);
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (!done8 && gap < 40);
      check("back2back gap", 32'(gap), 32'd9);
      check("back2back bcd", 32'(bcd8), 32'h128);
      pulses++;
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-conversion aborts without a done pulse.
    start8 = 1'b1; bin8 = 8'd173;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort bcd", 32'(bcd8), 32'd0);
    k = 0;
    repeat (12) begin @(negedge clk); if (done8) k++; end
    check("abort no done", 32'(k), 32'd0);
    run(1'b0, 42, 1'b0, "after abort");

    // Randomised operands.
    for (int i = 0; i < 20; i++) run(1'b0, $urandom_range(0, 255), 1'b0, "rand8");

    // Wide instance.
    run(1'b1, 65535, 1'b0, "w16 max");
    run(1'b1, 10000, 1'b0, "w16 10000");
    for (int i = 0; i < 10; i++) run(1'b1, $urandom_range(0, 65535), 1'b0, "rand16");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Sits downstream of the binary datapath and upstream of the 7-segment/display decode stage.
- Each BCD digit is corrected by one combinational add-3 cell per cycle (digit >= 5 -> digit + 3, else unchanged).
- Then the whole digit/binary shift register shifts left by one.

Parameters:
W, 8, width of binary input in bits (W >= 1).
D, 3, number of BCD output digits; must satisfy 10^D > 2^W - 1. Default 8/3 covers 0..255.

Ports:
clk    input   1     rising-edge clock, single clock domain
rst    input   1     synchronous reset, active-high
start  input   1     request conversion of bin; sampled only in IDLE
bin    input   W     binary operand, sampled on the edge that accepts start
busy   output  1     high while a conversion is in progress
done   output  1     one-cycle pulse: bcd holds a new valid result
bcd    output  4*D   packed BCD result; digit k occupies bits [4k+3:4k], digit 0 is the least significant

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is synchronous and active-high, sampled on the rising edge of clk, and has priority over everything.
  - On reset: state = IDLE, busy = 0, done = 0, bcd = 0, internal shift register and counter = 0.
  - Reset mid-conversion aborts the conversion; no done pulse follows.
- States:
  - IDLE: busy = 0. If start = 1 at the clock edge:
    - load binary part <= bin and digit part <= 0;
    - cnt <= W;
    - go to CONV.
    If start = 0, remain in IDLE.
  - CONV: busy = 1. Each edge does one iteration:
    - every digit passes through its add-3 cell;
    - {digits, binary} shifts left 1, with the MSB of the binary part entering digit-0 LSB;
    - cnt <= cnt - 1.
    On the edge where cnt == 1: bcd <= post-shift digits, done <= 1, go to IDLE.
- done: asserted only for the cycle after the final CONV edge; deasserted on every other edge.
- Latency: if start is sampled at edge N, busy is high after edge N through edge N+W. done and the new bcd are visible after edge N+W, i.e. W cycles of busy.
- start while busy = 1 is ignored; bin may change freely during CONV.
- Back-to-back operation: start asserted in the done cycle (state is IDLE) is accepted. Throughput is one result per W+1 cycles.
- bcd holds its last result until the next completion. It is not cleared at start and does not change during CONV.
- cnt is $clog2(W+1) bits wide and does not wrap.
- Add-3 cell: inputs 0..4 pass through unchanged; 5..9 map to 8..12 before the shift. Inputs 10..15 never occur when D is sized per the parameter rule.
- If D is undersized, upper digits are truncated silently; no error flag.

Test Plan:
1. rst high for 2 cycles, then start with bin = 0 -> busy high for exactly 8 cycles, done pulses once, bcd = 12'h000.
2. bin = 255, start pulse -> done exactly 8 cycles after the accepting edge, bcd = 12'h255. Then bin = 99 -> bcd = 12'h099.
3. start with bin = 200; during CONV raise start again with bin = 7 -> second request ignored, single done, bcd = 12'h200, busy never drops mid-run.
4. start held high continuously with bin = 128 -> successive done pulses every 9 cycles, each bcd = 12'h128.
5. start with bin = 173, assert rst on the 4th CONV cycle -> no done pulse, bcd = 0, busy = 0. A following start with bin = 42 yields bcd = 12'h042.
6. W = 16, D = 5: bin = 65535 -> bcd = 20'h65535 after 16 busy cycles. bin = 10000 -> bcd = 20'h10000.
